reg_dump_unit: RTL and testbench
================================

// Module: reg_dump_unit
// PURPOSE
//  Reads the register file back to an external observer by walking every
//  register in order and emitting one (address, data) word per register.
//  It drives a read-address port of the register file and receives that
//  port's read data. Words leave on a valid/ready stream, which replaces an
//  end-of-simulation memory dump and allows a test bench or debug port to
//  snapshot CPU state. While busy=1, the datapath muxes rd_addr onto the
//  register-file read port and stalls the CPU.
// PARAMETERS
//  NUM_REGS   32  number of registers walked; index range 0..NUM_REGS-1
//  ADDR_W     5   register address width; 2**ADDR_W >= NUM_REGS
//  DATA_W     32  register data width
//  SKIP_ZERO  0   1: start the walk at register 1 (r0 is hard-wired zero)
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       begin a dump; sampled only in IDLE
//  busy       out  1       dump in progress (ADDR, CAPTURE, SEND, DONE)
//  rd_addr    out  ADDR_W  register-file read address (registered)
//  rd_data    in   DATA_W  register-file read data (combinational from rd_addr)
//  out_valid  out  1       out_addr/out_data hold a valid word
//  out_ready  in   1       consumer accepts the word on a posedge with valid=1
//  out_addr   out  ADDR_W  register index of the current word
//  out_data   out  DATA_W  register contents of the current word
//  done       out  1       one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE, idx=0. Reset mid-dump aborts
//   immediately. No done pulse follows; any pending word is dropped.
//  FSM: IDLE -> ADDR -> CAPTURE -> SEND -> (ADDR | DONE) -> IDLE.
//  IDLE: busy=0, out_valid=0, rd_addr=0.
//   start=1 -> ADDR, with idx = SKIP_ZERO ? 1 : 0.
//  ADDR: rd_addr=idx. This is one settle cycle for the combinational read.
//  CAPTURE: out_data<=rd_data and out_addr<=idx on the exit edge;
//   out_valid<=1; go to SEND.
//  SEND: out_valid, out_addr and out_data are held stable until a posedge
//   with out_ready=1. On that edge: out_valid<=0.
//   If idx==NUM_REGS-1, go to DONE; else idx<=idx+1 and go to ADDR.
//   out_ready=0 stalls indefinitely. out_ready is ignored when out_valid=0.
//  DONE: done=1 and busy=1 for exactly one cycle, then IDLE (busy=0).
//  start outside IDLE is ignored, including start held high. A start held
//   high through DONE begins a new dump on the first IDLE cycle.
//  Throughput: 3 cycles per register with out_ready tied high.
//   Full dump (SKIP_ZERO=0) timing from the start-sampling edge:
//   word k has out_valid=1 in cycle 3k+3; done=1 in cycle 97.
//  Data coherence: the captured value is rd_data at the CAPTURE exit edge.
//   Register writes during busy are not blocked here; a write to register k
//   before its CAPTURE cycle is visible in the dump. idx never wraps past
//   NUM_REGS-1.
// TESTING
//  T1 Preload r0..r31 = 32'hA0+i; pulse start; out_ready=1.
//   -> 32 words, addr 0..31, data A0..BF in order; done=1 in cycle 97.
//  T2 As T1 with out_ready toggling 1-of-3 cycles.
//   -> no word lost or duplicated; data stable while valid && !ready;
//   exactly one done pulse.
//  T3 SKIP_ZERO=1 -> 31 words, first out_addr=1, last out_addr=31;
//   done one cycle after the last accept.
//  T4 Assert rst during SEND of word 10.
//   -> next cycle all outputs 0, state IDLE, no done pulse;
//   a fresh start yields a full dump from r0.
//  T5 Pulse start again while busy=1.
//   -> ignored; exactly 32 words and one done pulse.
//  T6 Write r20=32'hDEAD_BEEF while the dump is at word 5.
//   -> word 20 reads DEADBEEF; word 5 keeps its pre-write value.

Source files
------------

// File: rtl/reg_dump_unit.sv
// reg_dump_unit
//   Walks the register file in index order and emits one (address, data)
//   word per register on a valid/ready stream, so a bench or debug port can
//   snapshot CPU state without a memory dump. Each register takes three
//   cycles: drive the read address, capture the combinational read data,
//   then hold the word until the consumer accepts it.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset; aborts a dump immediately
//   start      begin a dump (only looked at while idle)
//   busy       dump in progress; datapath muxes rd_addr onto the RF port
//   rd_addr    registered register-file read address
//   rd_data    register-file read data, combinational from rd_addr
//   out_valid  out_addr/out_data hold a word
//   out_ready  consumer accepts the word on a posedge with out_valid=1
//   out_addr   register index of the current word
//   out_data   register contents of the current word
//   done       one-cycle pulse after the last word is accepted
module reg_dump_unit #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  // r0 is hard-wired zero on some cores, so the walk may start at r1.
  localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_ZERO ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      S_IDLE: begin
        rd_addr_d = '0;
        if (start) begin
          state_d   = S_ADDR;
          idx_d     = FIRST_IDX;
          // rd_addr is registered, so it must be loaded on the edge into ADDR
          rd_addr_d = FIRST_IDX;
        end
      end
      S_ADDR: begin
        // Settle cycle: the register file read is combinational from rd_addr.
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        out_data_d  = rd_data;
        out_addr_d  = idx_q;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d     = idx_q + 1'b1;
            rd_addr_d = idx_q + 1'b1;
            state_d   = S_ADDR;
          end
        end
      end
      S_DONE: begin
        rd_addr_d = '0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    rd_addr   = rd_addr_q;
    out_valid = out_valid_q;
    out_addr  = out_addr_q;
    out_data  = out_data_q;
  end

endmodule

// File: tb/tb_reg_dump_unit.sv
module tb_reg_dump_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rdy;
  logic        sel;

  logic        busy0, busy1, valid0, valid1, done0, done1;
  logic [4:0]  rd_addr0, rd_addr1, out_addr0, out_addr1;
  logic [31:0] rd_data0, rd_data1, out_data0, out_data1;

  logic [31:0] regs [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  reg_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start & ~sel), .busy(busy0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(valid0),
    .out_ready(rdy & ~sel), .out_addr(out_addr0), .out_data(out_data0),
    .done(done0)
  );

  reg_dump_unit #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .SKIP_ZERO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start & sel), .busy(busy1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(valid1),
    .out_ready(rdy & sel), .out_addr(out_addr1), .out_data(out_data1),
    .done(done1)
  );

  logic        m_busy, m_valid, m_done;
  logic [4:0]  m_addr, m_rd_addr;
  logic [31:0] m_data;
  assign m_busy    = sel ? busy1     : busy0;
  assign m_valid   = sel ? valid1    : valid0;
  assign m_done    = sel ? done1     : done0;
  assign m_addr    = sel ? out_addr1 : out_addr0;
  assign m_rd_addr = sel ? rd_addr1  : rd_addr0;
  assign m_data    = sel ? out_data1 : out_data0;

  typedef struct {
    bit skip;       // run the SKIP_ZERO=1 instance
    int mode;       // 0: ready high, 1: ready 1-of-3, 2: random ready + data
    int wr_word;    // write r20 while this word is offered (-1: none)
    bit restart;    // pulse start again while busy
    int exp_words;
    int exp_done;   // done cycle from the start-sampling edge (-1: not fixed)
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic preload(input int mode);
    for (int i = 0; i < 32; i++)
      regs[i] = (mode == 2) ? $urandom : (32'hA0 + 32'(i));
  endtask

  task automatic run_dump(input vec_t v);
    logic [31:0] expd [32];
    int          first, exp_i, cyc, last_acc, done_cnt;
    bit          pv, pr, post_done, finished;
    logic [4:0]  pa;
    logic [31:0] pd;

    sel = v.skip;
    preload(v.mode);
    // Reference model: the dump is the register file contents in index order
    for (int i = 0; i < 32; i++) expd[i] = regs[i];
    first = v.skip ? 1 : 0;

    @(negedge clk);
    start = 1'b1;
    rdy   = (v.mode == 0);
    @(negedge clk);
    start     = 1'b0;
    cyc       = 1;
    exp_i     = first;
    last_acc  = -10;
    done_cnt  = 0;
    pv        = 1'b0;
    pr        = 1'b0;
    pa        = '0;
    pd        = '0;
    post_done = 1'b0;
    finished  = 1'b0;

    while (!finished && cyc < 3000) begin
      if (post_done) begin
        chk("idle_busy_after_done", {63'd0, m_busy}, 64'd0);
        chk("done_single_pulse", {63'd0, m_done}, 64'd0);
        chk("idle_rd_addr", {59'd0, m_rd_addr}, 64'd0);
        finished = 1'b1;
      end else begin
        if (cyc == 1) chk("busy_after_start", {63'd0, m_busy}, 64'd1);
        start = (v.restart && cyc >= 10 && cyc <= 12);
        if (pv && !pr) begin
          chk("stall_valid", {63'd0, m_valid}, 64'd1);
          chk("stall_addr", {59'd0, m_addr}, {59'd0, pa});
          chk("stall_data", {32'd0, m_data}, {32'd0, pd});
        end
        case (v.mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        if (m_valid) begin
          if (v.mode == 0 && !(pv && !pr))
            chk("word_cycle", 64'(cyc), 64'(3 * (exp_i - first) + 3));
          if (rdy) begin
            if (exp_i > 31) begin
              chk("extra_word", 64'd1, 64'd0);
            end else begin
              chk("word_addr", {59'd0, m_addr}, 64'(exp_i));
              chk("word_data", {32'd0, m_data}, {32'd0, expd[exp_i]});
            end
            exp_i++;
            last_acc = cyc;
            if (v.wr_word >= 0 && int'(m_addr) == v.wr_word) begin
              regs[20] = 32'hDEAD_BEEF;
              expd[20] = 32'hDEAD_BEEF;
            end
          end
        end
        if (m_done) begin
          done_cnt++;
          chk("done_after_last_accept", 64'(cyc), 64'(last_acc + 1));
          chk("done_busy", {63'd0, m_busy}, 64'd1);
          if (v.exp_done >= 0) chk("done_cycle", 64'(cyc), 64'(v.exp_done));
          post_done = 1'b1;
        end
        pv = m_valid;
        pr = rdy;
        pa = m_addr;
        pd = m_data;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    rdy   = 1'b0;
    if (!finished) chk("dump_timeout", 64'd1, 64'd0);
    chk("word_count", 64'(exp_i - first), 64'(v.exp_words));
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, m_busy}, 64'd0);
    chk({tag, "_valid"}, {63'd0, m_valid}, 64'd0);
    chk({tag, "_done"}, {63'd0, m_done}, 64'd0);
    chk({tag, "_rd_addr"}, {59'd0, m_rd_addr}, 64'd0);
    chk({tag, "_out_addr"}, {59'd0, m_addr}, 64'd0);
    chk({tag, "_out_data"}, {32'd0, m_data}, 64'd0);
  endtask

  initial begin
    int  k;
    bit  hit;

    vecs[0] = '{skip: 1'b0, mode: 0, wr_word: -1, restart: 1'b0, exp_words: 32, exp_done: 97};
    vecs[1] = '{skip: 1'b0, mode: 1, wr_word: -1, restart: 1'b0, exp_words: 32, exp_done: -1};
    vecs[2] = '{skip: 1'b1, mode: 0, wr_word: -1, restart: 1'b0, exp_words: 31, exp_done: 94};
    vecs[3] = '{skip: 1'b0, mode: 0, wr_word: -1, restart: 1'b1, exp_words: 32, exp_done: 97};
    vecs[4] = '{skip: 1'b0, mode: 0, wr_word: 5,  restart: 1'b0, exp_words: 32, exp_done: 97};
    vecs[5] = '{skip: 1'b0, mode: 2, wr_word: -1, restart: 1'b0, exp_words: 32, exp_done: -1};
    vecs[6] = '{skip: 1'b1, mode: 2, wr_word: -1, restart: 1'b1, exp_words: 31, exp_done: -1};

    rst   = 1'b1;
    start = 1'b0;
    rdy   = 1'b0;
    sel   = 1'b0;
    preload(0);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset0");
    sel = 1'b1;
    check_reset_outputs("reset1");
    sel = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_dump(vecs[i]);

    // Reset while word 10 is waiting for acceptance
    sel = 1'b0;
    preload(0);
    @(negedge clk);
    start = 1'b1;
    rdy   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k     = 0;
    hit   = 1'b0;
    while (!hit && k < 200) begin
      if (m_valid && m_addr == 5'd10) begin
        rdy = 1'b0;
        hit = 1'b1;
      end else begin
        rdy = 1'b1;
        @(negedge clk);
        k++;
      end
    end
    if (!hit) chk("reach_word10_timeout", 64'd1, 64'd0);
    chk("word10_data_before_reset", {32'd0, m_data}, 64'h0000_00AA);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b0;
    check_reset_outputs("abort");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", {63'd0, m_done}, 64'd0);
      chk("abort_idle", {63'd0, m_busy}, 64'd0);
    end
    run_dump(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
